cpu_bus_arbiter: RTL

Shares the single DUT CPU register port (addr / rw / din / dout) between up to NUM_REQ requesters, such as a config sequencer, a status poller and a counter scraper. Each requester posts one transaction at a time with a valid/ack handshake. A round-robin arbiter serializes the transactions onto the bus and returns read data with a pulse. The block sits between the requesters and the DUT register port, in the same clock domain as the packet interface.

---
 rtl/cpu_bus_arbiter_if.sv | 30 +++
 rtl/cpu_bus_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter_if.sv
// Requester and DUT register-port signals shared by cpu_bus_arbiter.
// The master modport is the environment; the slave modport is the arbiter.
interface cpu_bus_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_rw;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ack;
   logic [NUM_REQ-1:0]        rd_valid;
   logic [DATA_W-1:0]         rd_data;
   logic [ADDR_W-1:0]         bus_addr;
   logic                      bus_rw;
   logic [DATA_W-1:0]         bus_dout;
   logic [DATA_W-1:0]         bus_din;
   logic                      busy;

   modport master (
      output req_valid, req_rw, req_addr, req_wdata, bus_din,
      input  req_ack, rd_valid, rd_data, bus_addr, bus_rw, bus_dout, busy
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_wdata, bus_din,
      output req_ack, rd_valid, rd_data, bus_addr, bus_rw, bus_dout, busy
   );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter serializing single-outstanding register transactions from
// NUM_REQ requesters onto one DUT CPU register port.
module cpu_bus_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned RD_LAT  = 1
) (
   input logic               clk,
   input logic               rst,
   cpu_bus_arbiter_if.slave  bus
);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   gnt_q, gnt_d;
   logic               rw_q, rw_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  rd_data_q, rd_data_d;
   logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;

   logic               found;
   logic [IDX_W-1:0]   pick;
   int unsigned        idx;

   // First requesting index at or after the pointer, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && bus.req_valid[idx[IDX_W-1:0]]) begin
            found = 1'b1;
            pick  = idx[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = '0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               gnt_d   = pick;
               rw_d    = bus.req_rw[pick];
               addr_d  = bus.req_addr[32'(pick)*ADDR_W +: ADDR_W];
               wdata_d = bus.req_wdata[32'(pick)*DATA_W +: DATA_W];
               state_d = StIssue;
            end
         end
         StIssue: begin
            ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
            if (rw_q) begin
               state_d = StIdle;
            end else begin
               state_d = StWait;
               cnt_d   = CNT_W'(RD_LAT);
            end
         end
         StWait: begin
            if (cnt_q == CNT_W'(1)) begin
               rd_data_d         = bus.bus_din;
               rd_valid_d[gnt_q] = 1'b1;
               cnt_d             = '0;
               state_d           = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         gnt_q      <= '0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Bus idles at 0/0/0 so an idle port looks like a harmless read of address 0.
   assign bus.req_ack  = (state_q == StIssue) ? (NUM_REQ'(1) << gnt_q) : '0;
   assign bus.bus_addr = (state_q != StIdle) ? addr_q : '0;
   assign bus.bus_rw   = (state_q == StIssue) && rw_q;
   assign bus.bus_dout = (state_q == StIssue) ? wdata_q : '0;
   assign bus.busy     = (state_q != StIdle);
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;

endmodule
